// File: rtl/ml_l3_ir_decoder.sv
// Nikon ML-L3 IR frame decoder: synchronizes and glitch-filters a demodulated IR
// receiver output, times each mark/space against tolerance windows and strobes shot or frame_err.
module ml_l3_ir_decoder #(
  parameter bit IR_ACTIVE_LOW = 1'b1,
  parameter int FILT_CYC      = 500,
  parameter int TOL_PCT       = 25,
  parameter int NOM_M1        = 100000,
  parameter int NOM_S1        = 1400000,
  parameter int NOM_M2        = 20000,
  parameter int NOM_S2        = 79000,
  parameter int NOM_M3        = 20000,
  parameter int NOM_S3        = 179000,
  parameter int NOM_M4        = 20000
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       ir_in,
  output logic       shot,
  output logic       frame_err,
  output logic [2:0] err_seg,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MIN_M1 = NOM_M1 - NOM_M1 * TOL_PCT / 100;
  localparam int MAX_M1 = NOM_M1 + NOM_M1 * TOL_PCT / 100;
  localparam int MIN_S1 = NOM_S1 - NOM_S1 * TOL_PCT / 100;
  localparam int MAX_S1 = NOM_S1 + NOM_S1 * TOL_PCT / 100;
  localparam int MIN_M2 = NOM_M2 - NOM_M2 * TOL_PCT / 100;
  localparam int MAX_M2 = NOM_M2 + NOM_M2 * TOL_PCT / 100;
  localparam int MIN_S2 = NOM_S2 - NOM_S2 * TOL_PCT / 100;
  localparam int MAX_S2 = NOM_S2 + NOM_S2 * TOL_PCT / 100;
  localparam int MIN_M3 = NOM_M3 - NOM_M3 * TOL_PCT / 100;
  localparam int MAX_M3 = NOM_M3 + NOM_M3 * TOL_PCT / 100;
  localparam int MIN_S3 = NOM_S3 - NOM_S3 * TOL_PCT / 100;
  localparam int MAX_S3 = NOM_S3 + NOM_S3 * TOL_PCT / 100;
  localparam int MIN_M4 = NOM_M4 - NOM_M4 * TOL_PCT / 100;
  localparam int MAX_M4 = NOM_M4 + NOM_M4 * TOL_PCT / 100;

  localparam int MAX_ALL = max2(max2(max2(MAX_M1, MAX_S1), max2(MAX_M2, MAX_S2)),
                                max2(max2(MAX_M3, MAX_S3), MAX_M4));
  // Counter must reach MAX+1 to detect a timeout, never below 21 bits.
  localparam int SEG_W = max2(21, $clog2(MAX_ALL + 2));
  localparam logic [SEG_W-1:0] SEG_SAT = '1;
  localparam int FC_W = max2(1, $clog2(FILT_CYC));

  // State encoding doubles as the segment index reported on err_seg.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M1   = 3'd1,
    ST_S1   = 3'd2,
    ST_M2   = 3'd3,
    ST_S2   = 3'd4,
    ST_M3   = 3'd5,
    ST_S3   = 3'd6,
    ST_M4   = 3'd7
  } state_t;

  logic             r_sync1, r_sync2;
  logic             r_ir_f, r_ir_f_d;
  logic [FC_W-1:0]  r_filt_cnt;
  logic [SEG_W-1:0] r_seg_cnt;
  state_t           r_state;
  logic             r_shot, r_frame_err, r_busy;
  logic [2:0]       r_err_seg;
  logic [7:0]       r_frame_cnt;

  logic             w_mark, w_diff, w_flip, w_edge, w_rise, w_len_ok;
  logic [SEG_W-1:0] w_seg_min, w_seg_max;
  state_t           w_state_nxt;
  logic             w_shot_nxt, w_err_nxt;

  assign w_mark = IR_ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_diff = w_mark ^ r_ir_f;
  assign w_flip = w_diff && (r_filt_cnt == FC_W'(FILT_CYC - 1));
  assign w_edge = r_ir_f ^ r_ir_f_d;
  assign w_rise = r_ir_f & ~r_ir_f_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_sync1    <= IR_ACTIVE_LOW;
      r_sync2    <= IR_ACTIVE_LOW;
      r_ir_f     <= 1'b0;
      r_ir_f_d   <= 1'b0;
      r_filt_cnt <= '0;
      r_seg_cnt  <= '0;
    end else begin
      r_sync1  <= ir_in;
      r_sync2  <= r_sync1;
      r_ir_f_d <= r_ir_f;
      if (!w_diff) begin
        r_filt_cnt <= '0;
      end else if (w_flip) begin
        r_filt_cnt <= '0;
        r_ir_f     <= ~r_ir_f;
      end else begin
        r_filt_cnt <= r_filt_cnt + FC_W'(1);
      end
      if (w_edge)
        r_seg_cnt <= SEG_W'(1);
      else if (r_seg_cnt != SEG_SAT)
        r_seg_cnt <= r_seg_cnt + SEG_W'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_seg_min = '0;
    w_seg_max = SEG_SAT;
    case (r_state)
      ST_M1:   begin w_seg_min = SEG_W'(MIN_M1); w_seg_max = SEG_W'(MAX_M1); end
      ST_S1:   begin w_seg_min = SEG_W'(MIN_S1); w_seg_max = SEG_W'(MAX_S1); end
      ST_M2:   begin w_seg_min = SEG_W'(MIN_M2); w_seg_max = SEG_W'(MAX_M2); end
      ST_S2:   begin w_seg_min = SEG_W'(MIN_S2); w_seg_max = SEG_W'(MAX_S2); end
      ST_M3:   begin w_seg_min = SEG_W'(MIN_M3); w_seg_max = SEG_W'(MAX_M3); end
      ST_S3:   begin w_seg_min = SEG_W'(MIN_S3); w_seg_max = SEG_W'(MAX_S3); end
      ST_M4:   begin w_seg_min = SEG_W'(MIN_M4); w_seg_max = SEG_W'(MAX_M4); end
      default: ;
    endcase
  end

  assign w_len_ok = (r_seg_cnt >= w_seg_min) && (r_seg_cnt <= w_seg_max);

  always_comb begin
    w_state_nxt = r_state;
    w_shot_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_rise)
        w_state_nxt = ST_M1;
    end else if (w_edge) begin
      if (w_len_ok) begin
        w_shot_nxt  = (r_state == ST_M4);
        w_state_nxt = (r_state == ST_M4) ? ST_IDLE : state_t'(r_state + 3'd1);
      end else begin
        // A bad space ends on a rising edge, which is itself a fresh M1 start.
        w_err_nxt   = 1'b1;
        w_state_nxt = w_rise ? ST_M1 : ST_IDLE;
      end
    end else if (r_seg_cnt > w_seg_max) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shot      <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_seg   <= 3'd0;
      r_frame_cnt <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shot      <= w_shot_nxt;
      r_frame_err <= w_err_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_err_nxt)
        r_err_seg <= r_state;
      if (w_shot_nxt)
        r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign shot      = r_shot;
  assign frame_err = r_frame_err;
  assign err_seg   = r_err_seg;
  assign frame_cnt = r_frame_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ml_l3_ir_decoder.sv
// Directed bench for ml_l3_ir_decoder with scaled-down segment lengths; expected strobes
// are queued when the decisive raw edge is driven and matched when the DUT strobes.
module tb_ml_l3_ir_decoder;

  localparam bit ACT_LOW = 1'b1;
  localparam int FILT    = 3;
  localparam int M1 = 24, S1 = 48, M2 = 12, S2 = 20, M3 = 12, S3 = 28, M4 = 12;
  // 25 % windows of the scaled nominals, worked out by hand.
  localparam int M1_MAX = 30;
  localparam int M2_MIN = 9;
  localparam int M2_MAX = 15;
  localparam int S1_BAD = 20;
  localparam int GAP    = 12;

  logic       clk_50M = 1'b0;
  logic       rst;
  logic       ir_in;
  logic       shot, frame_err, busy;
  logic [2:0] err_seg;
  logic [7:0] frame_cnt;

  always #10 clk_50M = ~clk_50M;

  ml_l3_ir_decoder #(
    .IR_ACTIVE_LOW(ACT_LOW),
    .FILT_CYC     (FILT),
    .TOL_PCT      (25),
    .NOM_M1       (M1),
    .NOM_S1       (S1),
    .NOM_M2       (M2),
    .NOM_S2       (S2),
    .NOM_M3       (M3),
    .NOM_S3       (S3),
    .NOM_M4       (M4)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .ir_in    (ir_in),
    .shot     (shot),
    .frame_err(frame_err),
    .err_seg  (err_seg),
    .frame_cnt(frame_cnt),
    .busy     (busy)
  );

  typedef struct {
    bit          is_err;
    logic [2:0]  seg;
    logic [7:0]  cnt;
    int unsigned t_lo;
    int unsigned t_hi;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic [7:0]  m_cnt  = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_strobe(input string tag, input bit is_err, input logic [2:0] seg,
                               input int unsigned lo_off, input int unsigned hi_off);
    exp_t e;
    if (!is_err) m_cnt = m_cnt + 8'd1;
    e.is_err = is_err;
    e.seg    = seg;
    e.cnt    = m_cnt;
    e.t_lo   = cyc + lo_off;
    e.t_hi   = cyc + hi_off;
    e.tag    = tag;
    sb.push_back(e);
  endtask

  // One clock; outputs sampled on the falling edge and any strobe matched to the queue.
  task automatic tick();
    exp_t e;
    @(negedge clk_50M);
    cyc++;
    if (shot !== 1'b0 || frame_err !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, shot, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_kind"}, {30'd0, shot, frame_err}, e.is_err ? 32'd1 : 32'd2);
        check({e.tag, "_cnt"}, 32'(frame_cnt), 32'(e.cnt));
        if (e.is_err) check({e.tag, "_seg"}, 32'(err_seg), 32'(e.seg));
        checks++;
        assert (cyc >= e.t_lo && cyc <= e.t_hi) else begin
          errors++;
          $error("FAIL %s_time observed=%0d expected=%0d..%0d", e.tag, cyc, e.t_lo, e.t_hi);
        end
      end
    end
  endtask

  task automatic drive(input bit mark, input int n);
    ir_in = ACT_LOW ? ~mark : mark;
    repeat (n) tick();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic frame(input string tag, input int m2w, input bit glitch);
    drive(1'b1, M1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (glitch) begin
      drive(1'b0, 20);
      drive(1'b1, 2);
      drive(1'b0, S1 - 22);
    end else begin
      drive(1'b0, S1);
    end
    drive(1'b1, m2w);
    drive(1'b0, S2);
    drive(1'b1, M3);
    drive(1'b0, S3);
    drive(1'b1, M4);
    expect_strobe(tag, 1'b0, 3'd0, FILT + 2, FILT + 4);
    drive(1'b0, GAP);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    ir_in = ACT_LOW;
    repeat (3) tick();
    check("rst_shot", 32'(shot), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_seg", 32'(err_seg), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    drive(1'b0, 10);

    // Short spike on an idle line must not start a frame.
    drive(1'b1, 2);
    drive(1'b0, 30);
    check("idle_spike_busy", 32'(busy), 32'd0);

    frame("nominal", M2, 1'b0);
    drain("nominal", 50);
    check("nominal_cnt", 32'(frame_cnt), 32'd1);
    check("nominal_seg", 32'(err_seg), 32'd0);

    frame("glitch_s1", M2, 1'b1);
    drain("glitch_s1", 50);

    frame("m2_min", M2_MIN, 1'b0);
    frame("m2_max", M2_MAX, 1'b0);
    drain("m2_bounds", 50);
    check("m2_bounds_cnt", 32'(frame_cnt), 32'd4);

    drive(1'b1, M1);
    drive(1'b0, S1);
    drive(1'b1, M2_MIN - 1);
    expect_strobe("m2_short", 1'b1, 3'd3, FILT + 2, FILT + 4);
    drive(1'b0, 60);
    drain("m2_short", 50);
    check("m2_short_busy", 32'(busy), 32'd0);

    drive(1'b1, M1);
    drive(1'b0, S1);
    drive(1'b1, M2_MAX + 1);
    expect_strobe("m2_long", 1'b1, 3'd3, FILT + 2, FILT + 4);
    drive(1'b0, 60);
    drain("m2_long", 50);

    // Stuck mark: abort once the segment passes M1's maximum, then stay quiet.
    expect_strobe("m1_timeout", 1'b1, 3'd1, FILT + 3 + M1_MAX, FILT + 5 + M1_MAX);
    drive(1'b1, 200);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_seg", 32'(err_seg), 32'd1);
    drive(1'b0, 40);
    drain("m1_timeout", 50);

    drive(1'b1, M1);
    drive(1'b0, S1_BAD);
    expect_strobe("s1_short", 1'b1, 3'd2, FILT + 2, FILT + 4);
    frame("restart", M2, 1'b0);
    drain("restart", 50);
    check("restart_cnt", 32'(frame_cnt), 32'd5);

    // Reset in the middle of S2 aborts silently.
    drive(1'b1, M1);
    drive(1'b0, S1);
    drive(1'b1, M2);
    drive(1'b0, 10);
    rst = 1'b1;
    repeat (3) tick();
    rst   = 1'b0;
    m_cnt = 8'd0;
    check("midrst_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_seg", 32'(err_seg), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    drive(1'b0, 50);
    frame("post_rst_a", M2, 1'b0);
    drive(1'b0, 100);
    frame("post_rst_b", M2, 1'b0);
    drain("post_rst", 50);
    check("post_rst_cnt", 32'(frame_cnt), 32'd2);

    while (m_cnt != 8'd255) frame("fill", M2, 1'b0);
    drain("fill", 50);
    check("fill_cnt", 32'(frame_cnt), 32'd255);
    frame("wrap", M2, 1'b0);
    drain("wrap", 50);
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    drive(1'b0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
